alu_cmd_sequencer: RTL and testbench

- Sequential front/back end for the combinational 4-bit ALU (alu_8bit).
- Accepts a two-byte command stream over a valid/ready handshake and drives the ALU operand/opcode ports from registers.
- Captures Y/zero/carry into a result register and presents it downstream over a second valid/ready handshake.
- Keeps an accumulator of the last result so chained operations can reuse it as operand A.

---
 rtl/alu_pkg.sv | 27 ++
 rtl/alu_cmd_sequencer_if.sv | 22 ++
 rtl/alu_8bit.sv | 38 +++
 rtl/alu_cmd_sequencer.sv | 123 ++++++++++++
 tb/tb_alu_cmd_sequencer.sv | 205 ++++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// Shared constants and types for the ALU command sequencer and its companion ALU.
// Holds opcode values, the sequencer state encoding and the command byte-0 field layout.
package alu_pkg;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_NOT = 3'b101;
  localparam logic [2:0] OP_SHL = 3'b110;
  localparam logic [2:0] OP_SHR = 3'b111;

  // Byte 0: [7:5]=sel, [4]=use_acc, [3:0]=A.  Byte 1: [3:0]=B.
  localparam int SEL_LSB     = 5;
  localparam int USE_ACC_BIT = 4;
  localparam int A_LSB       = 0;
  localparam int B_LSB       = 0;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAIT_B = 2'd1,
    EXEC   = 2'd2,
    HOLD   = 2'd3
  } state_t;

endpackage

// File: rtl/alu_cmd_sequencer_if.sv
// Command-in / result-out handshake bundle between a host and the ALU command sequencer.
// The host uses the master modport, the sequencer the slave modport.
interface alu_cmd_sequencer_if #(
  parameter int WIDTH = 4
);
  logic             in_valid;
  logic [7:0]       in_data;
  logic             in_ready;
  logic             out_valid;
  logic [WIDTH+1:0] out_data;
  logic             out_ready;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/alu_8bit.sv
// Combinational 4-bit ALU driven by the command sequencer.
// Carry is the carry-out for ADD, the borrow for SUB and the shifted-out bit for shifts.
module alu_8bit
  import alu_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       sel,
  output logic [WIDTH-1:0] y,
  output logic             zero,
  output logic             carry
);

  logic [WIDTH:0] w_res;

  // Operation decode
  always_comb begin
    w_res = '0;
    case (sel)
      OP_ADD:  w_res = {1'b0, a} + {1'b0, b};
      OP_SUB:  w_res = {1'b0, a} - {1'b0, b};
      OP_AND:  w_res = {1'b0, a & b};
      OP_OR:   w_res = {1'b0, a | b};
      OP_XOR:  w_res = {1'b0, a ^ b};
      OP_NOT:  w_res = {1'b0, ~a};
      OP_SHL:  w_res = {a, 1'b0};
      OP_SHR:  w_res = {a[0], 1'b0, a[WIDTH-1:1]};
      default: w_res = '0;
    endcase
  end

  assign y     = w_res[WIDTH-1:0];
  assign carry = w_res[WIDTH];
  assign zero  = (w_res[WIDTH-1:0] == '0);

endmodule

// File: rtl/alu_cmd_sequencer.sv
// Two-byte command front end and result back end for the combinational ALU.
// Latches opcode/operands, samples the ALU after one stable cycle, holds the result until taken.
module alu_cmd_sequencer
  import alu_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int SEL_W = 3,
  parameter int CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  alu_cmd_sequencer_if.slave   bus,
  output logic [WIDTH-1:0]     alu_a,
  output logic [WIDTH-1:0]     alu_b,
  output logic [SEL_W-1:0]     alu_sel,
  input  logic [WIDTH-1:0]     alu_y,
  input  logic                 alu_zero,
  input  logic                 alu_carry,
  output logic [WIDTH-1:0]     acc,
  output logic [CNT_W-1:0]     op_count
);

  state_t           r_state;
  state_t           w_next_state;
  logic             w_in_ready;
  logic             w_xfer;
  logic [WIDTH-1:0] r_alu_a;
  logic [WIDTH-1:0] r_alu_b;
  logic [SEL_W-1:0] r_alu_sel;
  logic [WIDTH+1:0] r_out_data;
  logic             r_out_valid;
  logic [WIDTH-1:0] r_acc;
  logic [CNT_W-1:0] r_op_count;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state and input-ready decode
  always_comb begin
    w_next_state = r_state;
    w_in_ready   = 1'b0;
    case (r_state)
      IDLE: begin
        w_in_ready = 1'b1;
        if (bus.in_valid) w_next_state = WAIT_B;
        else              w_next_state = IDLE;
      end
      WAIT_B: begin
        w_in_ready = 1'b1;
        if (bus.in_valid) w_next_state = EXEC;
        else              w_next_state = WAIT_B;
      end
      EXEC: begin
        w_next_state = HOLD;
      end
      HOLD: begin
        if (bus.out_ready) w_next_state = IDLE;
        else               w_next_state = HOLD;
      end
      default: begin
        w_next_state = IDLE;
      end
    endcase
  end

  assign w_xfer = bus.in_valid && w_in_ready;

  // Operand capture, result capture and bookkeeping
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_alu_a     <= '0;
      r_alu_b     <= '0;
      r_alu_sel   <= '0;
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
      r_acc       <= '0;
      r_op_count  <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_xfer) begin
            r_alu_sel <= bus.in_data[SEL_LSB +: SEL_W];
            r_alu_a   <= bus.in_data[USE_ACC_BIT] ? r_acc : bus.in_data[A_LSB +: WIDTH];
          end
        end
        WAIT_B: begin
          if (w_xfer) begin
            r_alu_b <= bus.in_data[B_LSB +: WIDTH];
          end
        end
        EXEC: begin
          // ALU inputs have been stable from registers for this whole cycle.
          r_out_data  <= {alu_carry, alu_zero, alu_y};
          r_acc       <= alu_y;
          r_op_count  <= r_op_count + CNT_W'(1);
          r_out_valid <= 1'b1;
        end
        HOLD: begin
          if (bus.out_ready) r_out_valid <= 1'b0;
        end
        default: begin
          r_out_valid <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.out_data  = r_out_data;
  assign alu_a         = r_alu_a;
  assign alu_b         = r_alu_b;
  assign alu_sel       = r_alu_sel;
  assign acc           = r_acc;
  assign op_count      = r_op_count;

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Randomized self-checking bench for alu_cmd_sequencer wired to alu_8bit.
// Expected results come from an arithmetic reference of the command/ALU rules.
module tb_alu_cmd_sequencer;

  localparam int WIDTH = 4;
  localparam int SEL_W = 3;
  localparam int CNT_W = 8;

  logic             clk;
  logic             rst_n;
  logic [WIDTH-1:0] alu_a;
  logic [WIDTH-1:0] alu_b;
  logic [SEL_W-1:0] alu_sel;
  logic [WIDTH-1:0] alu_y;
  logic             alu_zero;
  logic             alu_carry;
  logic [WIDTH-1:0] acc;
  logic [CNT_W-1:0] op_count;

  int n_checks;
  int n_fail;

  logic [3:0] acc_m;
  logic [7:0] cnt_m;

  alu_cmd_sequencer_if #(.WIDTH(WIDTH)) bus ();

  alu_cmd_sequencer #(.WIDTH(WIDTH), .SEL_W(SEL_W), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus.slave),
    .alu_a     (alu_a),
    .alu_b     (alu_b),
    .alu_sel   (alu_sel),
    .alu_y     (alu_y),
    .alu_zero  (alu_zero),
    .alu_carry (alu_carry),
    .acc       (acc),
    .op_count  (op_count)
  );

  alu_8bit #(.WIDTH(WIDTH)) u_alu (
    .a     (alu_a),
    .b     (alu_b),
    .sel   (alu_sel),
    .y     (alu_y),
    .zero  (alu_zero),
    .carry (alu_carry)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference result {carry, zero, y} from plain integer arithmetic.
  function automatic logic [5:0] ref_alu(input logic [2:0] sel, input logic [3:0] a, input logic [3:0] b);
    int ia, ib, r, c;
    ia = a; ib = b; c = 0; r = 0;
    case (sel)
      3'd0: begin r = (ia + ib) % 16; c = (ia + ib) >= 16 ? 1 : 0; end
      3'd1: begin r = (ia - ib + 16) % 16; c = (ia < ib) ? 1 : 0; end
      3'd2: r = ia & ib;
      3'd3: r = ia | ib;
      3'd4: r = ia ^ ib;
      3'd5: r = 15 - ia;
      3'd6: begin r = (ia * 2) % 16; c = ia / 8; end
      default: begin r = ia / 2; c = ia % 2; end
    endcase
    ref_alu = {c[0], (r == 0), r[3:0]};
  endfunction

  // Issue one command from IDLE and follow it through to IDLE again.
  task automatic do_cmd(input logic [7:0] b0, input logic [7:0] b1, input int gap, input int bp);
    logic [2:0] es;
    logic [3:0] ea;
    logic [3:0] eb;
    logic [5:0] er;
    es = b0[7:5];
    ea = b0[4] ? acc_m : b0[3:0];
    eb = b1[3:0];
    er = ref_alu(es, ea, eb);
    chk("idle_in_ready", 32'(bus.in_ready), 32'd1);
    bus.in_valid = 1'b1;
    bus.in_data  = b0;
    @(negedge clk);
    for (int g = 0; g < gap; g++) begin
      bus.in_valid = 1'b0;
      bus.in_data  = 8'($urandom);
      chk("waitb_in_ready", 32'(bus.in_ready), 32'd1);
      @(negedge clk);
    end
    bus.in_valid = 1'b1;
    bus.in_data  = b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    if (bp > 0) bus.out_ready = 1'b0;
    chk("exec_out_valid", 32'(bus.out_valid), 32'd0);
    chk("exec_in_ready", 32'(bus.in_ready), 32'd0);
    chk("alu_sel", 32'(alu_sel), 32'(es));
    chk("alu_a", 32'(alu_a), 32'(ea));
    chk("alu_b", 32'(alu_b), 32'(eb));
    @(negedge clk);
    acc_m = er[3:0];
    cnt_m = cnt_m + 8'd1;
    chk("hold_out_valid", 32'(bus.out_valid), 32'd1);
    chk("out_data", 32'(bus.out_data), 32'(er));
    chk("acc", 32'(acc), 32'(acc_m));
    chk("op_count", 32'(op_count), 32'(cnt_m));
    for (int k = 0; k < bp; k++) begin
      bus.in_valid = 1'($urandom_range(0, 1));
      bus.in_data  = 8'($urandom);
      @(negedge clk);
      chk("bp_out_valid", 32'(bus.out_valid), 32'd1);
      chk("bp_out_data", 32'(bus.out_data), 32'(er));
      chk("bp_in_ready", 32'(bus.in_ready), 32'd0);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    chk("done_out_valid", 32'(bus.out_valid), 32'd0);
    chk("done_in_ready", 32'(bus.in_ready), 32'd1);
    chk("done_alu_a_kept", 32'(alu_a), 32'(ea));
    chk("done_op_count", 32'(op_count), 32'(cnt_m));
  endtask

  task automatic apply_reset_check(input string tag);
    #2 rst_n = 1'b0;
    #1;
    chk({tag, "_alu_a"}, 32'(alu_a), 32'd0);
    chk({tag, "_alu_b"}, 32'(alu_b), 32'd0);
    chk({tag, "_alu_sel"}, 32'(alu_sel), 32'd0);
    chk({tag, "_out_data"}, 32'(bus.out_data), 32'd0);
    chk({tag, "_out_valid"}, 32'(bus.out_valid), 32'd0);
    chk({tag, "_acc"}, 32'(acc), 32'd0);
    chk({tag, "_op_count"}, 32'(op_count), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    acc_m = 4'd0;
    cnt_m = 8'd0;
    @(negedge clk);
    chk({tag, "_in_ready"}, 32'(bus.in_ready), 32'd1);
  endtask

  initial begin
    n_checks      = 0;
    n_fail        = 0;
    acc_m         = 4'd0;
    cnt_m         = 8'd0;
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = 8'h00;
    bus.out_ready = 1'b1;
    #1;
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_acc", 32'(acc), 32'd0);
    chk("rst_op_count", 32'(op_count), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);

    do_cmd(8'h05, 8'h03, 0, 0);
    chk("add_result", 32'(bus.out_data), 32'h08);
    do_cmd(8'h25, 8'h03, 1, 0);
    do_cmd(8'h50, 8'h03, 0, 0);
    chk("chain_acc", 32'(acc), 32'h2);
    do_cmd(8'h23, 8'h03, 0, 0);
    chk("zero_data", 32'(bus.out_data), 32'h10);
    do_cmd(8'h17, 8'hF9, 0, 5);

    for (int i = 0; i < 40; i++) begin
      do_cmd(8'($urandom), 8'($urandom), $urandom_range(0, 2), ($urandom_range(0, 3) == 0) ? $urandom_range(1, 4) : 0);
    end

    do_cmd(8'h05, 8'h03, 0, 0);
    bus.in_valid = 1'b1;
    bus.in_data  = 8'h05;
    @(negedge clk);
    bus.in_valid = 1'b0;
    apply_reset_check("midop_rst");
    do_cmd(8'h01, 8'h01, 0, 0);
    chk("post_rst_y", 32'(bus.out_data), 32'h02);
    chk("post_rst_count", 32'(op_count), 32'd1);

    do_cmd(8'h01, 8'h01, 0, 1);
    apply_reset_check("pre_wrap_rst");
    for (int i = 0; i < 256; i++) begin
      do_cmd({3'b000, 1'($urandom_range(0, 1)), 4'($urandom)}, 8'($urandom), 0, 0);
    end
    chk("wrap_count", 32'(op_count), 32'd0);
    do_cmd(8'h07, 8'h09, 0, 0);
    chk("wrap_result", 32'(bus.out_data), 32'h30);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
